// File: rtl/ascii_to_fifo_pkg.sv
// Shared types and constants for the ASCII hex line to 128-bit FIFO word assembler.
package ascii_to_fifo_pkg;

    localparam int unsigned WORD_W  = 128;
    localparam int unsigned NIBBLES = 32;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        StHunt    = 2'd0,
        StCollect = 2'd1,
        StPush    = 2'd2
    } state_e;

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder; lowercase digits optional.
module hex_ascii_decode #(
    parameter bit LOWERCASE_EN = 1'b1
) (
    input  logic [7:0] char_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        is_hex_o = 1'b0;
        nibble_o = 4'h0;
        if (char_i >= 8'h30 && char_i <= 8'h39) begin
            is_hex_o = 1'b1;
            nibble_o = char_i[3:0];
        end else if (char_i >= 8'h41 && char_i <= 8'h46) begin
            // 'A'..'F' have low nibble 1..6
            is_hex_o = 1'b1;
            nibble_o = char_i[3:0] + 4'd9;
        end else if (LOWERCASE_EN && char_i >= 8'h61 && char_i <= 8'h66) begin
            is_hex_o = 1'b1;
            nibble_o = char_i[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/ascii_to_fifo.sv
// Assembles LF-framed lines of 32 ASCII hex digits into 128-bit FIFO writes.
module ascii_to_fifo
    import ascii_to_fifo_pkg::*;
#(
    parameter bit LOWERCASE_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [7:0]        ASCII_DATA,
    input  logic              ASCII_VALID,
    output logic              ASCII_READY,
    input  logic              FIFO_FULL,
    output logic [WORD_W-1:0] FIFO_DATA,
    output logic              FIFO_WRITE,
    output logic              ERROR,
    output logic [7:0]        ERR_COUNT
);

    state_e            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              error_q, error_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic       is_hex;
    logic [3:0] nibble;
    logic       accept;
    logic       err_set;

    hex_ascii_decode #(
        .LOWERCASE_EN (LOWERCASE_EN)
    ) u_decode (
        .char_i   (ASCII_DATA),
        .is_hex_o (is_hex),
        .nibble_o (nibble)
    );

    assign ASCII_READY = (state_q != StPush);
    assign FIFO_WRITE  = (state_q == StPush) & ~FIFO_FULL;
    assign accept      = ASCII_VALID & ASCII_READY;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_set = 1'b0;
        unique case (state_q)
            StHunt: begin
                if (accept && ASCII_DATA == ASCII_LF) begin
                    cnt_d   = 6'd0;
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (accept && ASCII_DATA != ASCII_CR) begin
                    if (is_hex) begin
                        data_d = {data_q[WORD_W-5:0], nibble};
                        cnt_d  = cnt_q + 6'd1;
                        if (cnt_q == 6'(NIBBLES - 1)) begin
                            state_d = StPush;
                        end
                    end else if (ASCII_DATA == ASCII_LF) begin
                        // A bare LF is a blank line; only a partial line is an error
                        err_set = (cnt_q != 6'd0);
                        cnt_d   = 6'd0;
                    end else begin
                        err_set = 1'b1;
                        cnt_d   = 6'd0;
                        state_d = StHunt;
                    end
                end
            end
            StPush: begin
                if (!FIFO_FULL) begin
                    state_d = StHunt;
                end
            end
            default: state_d = StHunt;
        endcase

        error_d   = err_set;
        err_cnt_d = (err_set && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= StHunt;
            cnt_q     <= 6'd0;
            data_q    <= '0;
            error_q   <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign FIFO_DATA = data_q;
    assign ERROR     = error_q;
    assign ERR_COUNT = err_cnt_q;

endmodule

// File: tb/tb_ascii_to_fifo.sv
// Directed bench for ascii_to_fifo; a second instance exercises LOWERCASE_EN=0.
module tb_ascii_to_fifo;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   ascii_data = 8'h00;
    logic         ascii_valid = 1'b0;
    logic         fifo_full = 1'b0;

    logic         ready1, write1, error1;
    logic [127:0] data1;
    logic [7:0]   errc1;
    logic         ready0, write0, error0;
    logic [127:0] data0;
    logic [7:0]   errc0;

    int           tests_run = 0;
    int           tests_failed = 0;
    int           wr1 = 0, wr0 = 0, ep1 = 0, ep0 = 0;
    logic [127:0] wdata1 = '0;

    localparam logic [127:0] W_COUNT = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] W_ONES  = {128{1'b1}};
    localparam logic [127:0] W_LOWER = 128'hABCDEF0123456789ABCDEF0123456789;
    localparam logic [127:0] W_DESC  = 128'hFEDCBA9876543210FEDCBA9876543210;

    ascii_to_fifo #(.LOWERCASE_EN(1'b1)) dut (
        .CLK (clk), .RESET_N (rst_n), .ASCII_DATA (ascii_data), .ASCII_VALID (ascii_valid),
        .ASCII_READY (ready1), .FIFO_FULL (fifo_full), .FIFO_DATA (data1),
        .FIFO_WRITE (write1), .ERROR (error1), .ERR_COUNT (errc1)
    );

    ascii_to_fifo #(.LOWERCASE_EN(1'b0)) dut_lc0 (
        .CLK (clk), .RESET_N (rst_n), .ASCII_DATA (ascii_data), .ASCII_VALID (ascii_valid),
        .ASCII_READY (ready0), .FIFO_FULL (fifo_full), .FIFO_DATA (data0),
        .FIFO_WRITE (write0), .ERROR (error0), .ERR_COUNT (errc0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write1) begin wr1++; wdata1 = data1; end
        if (write0) wr0++;
        if (error1) ep1++;
        if (error0) ep0++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_char(input logic [7:0] c);
        int n = 0;
        ascii_data  = c;
        ascii_valid = 1'b1;
        while (!ready1 && n < 50) begin @(posedge clk); #1; n++; end
        if (!ready1) begin
            tests_run++; tests_failed++;
            $display("FAIL send_ready_timeout: ASCII_READY=%b required 1", ready1);
        end
        @(posedge clk); #1;
        ascii_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fifo_full = 1'b0;
        idle(2);
        tests_run++;
        if ({ready1, write1, error1, errc1} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            tests_failed++;
            $display("FAIL reset_ctl: rdy/wr/err/cnt=%b/%b/%b/%0d required 1/0/0/0",
                     ready1, write1, error1, errc1);
        end
        tests_run++;
        if (data1 !== 128'd0) begin
            tests_failed++; $display("FAIL reset_data: got %h required 0", data1);
        end
        tests_run++;
        if ({ready0, write0, error0, errc0, data0} !== {1'b1, 1'b0, 1'b0, 8'd0, 128'd0}) begin
            tests_failed++;
            $display("FAIL reset_lc0: rdy/wr/err/cnt=%b/%b/%b/%0d data=%h required 1/0/0/0 0",
                     ready0, write0, error0, errc0, data0);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_word();
        int s = wr1;
        send_char(8'h0A);
        send_str("0123456789ABCDEF0123456789ABCDEF");
        tests_run++;
        if ({write1, ready1} !== 2'b10) begin
            tests_failed++;
            $display("FAIL word_latency: wr/rdy=%b/%b required 1/0", write1, ready1);
        end
        tests_run++;
        if (data1 !== W_COUNT) begin
            tests_failed++; $display("FAIL word_data: got %h required %h", data1, W_COUNT);
        end
        idle(1);
        tests_run++;
        if ((wr1 - s) !== 1 || wdata1 !== W_COUNT) begin
            tests_failed++;
            $display("FAIL word_write: writes=%0d data=%h required 1 %h", wr1 - s, wdata1, W_COUNT);
        end
        tests_run++;
        if ({write1, ready1} !== 2'b01) begin
            tests_failed++;
            $display("FAIL word_back_hunt: wr/rdy=%b/%b required 0/1", write1, ready1);
        end
    endtask

    task automatic test_full();
        int s;
        fifo_full = 1'b1;
        s = wr1;
        send_char(8'h0A);
        send_str("0123456789ABCDEF0123456789ABCDEF");
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if ({data1, ready1, write1} !== {W_COUNT, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL full_hold[%0d]: data=%h rdy=%b wr=%b required %h 0 0",
                         i, data1, ready1, write1, W_COUNT);
            end
            if (i < 9) idle(1);
        end
        fifo_full = 1'b0;
        #1;
        tests_run++;
        if (write1 !== 1'b1) begin
            tests_failed++; $display("FAIL full_release: FIFO_WRITE=%b required 1", write1);
        end
        idle(4);
        tests_run++;
        if ((wr1 - s) !== 1 || wdata1 !== W_COUNT || ready1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_once: writes=%0d data=%h rdy=%b required 1 %h 1",
                     wr1 - s, wdata1, ready1, W_COUNT);
        end
    endtask

    task automatic test_bad_char();
        int s = wr1;
        int e = ep1;
        send_char(8'h0A);
        send_str("12G");
        tests_run++;
        if ({error1, errc1} !== {1'b1, 8'd1}) begin
            tests_failed++;
            $display("FAIL bad_char_err: ERROR=%b ERR_COUNT=%0d required 1 1", error1, errc1);
        end
        idle(1);
        tests_run++;
        if (error1 !== 1'b0) begin
            tests_failed++; $display("FAIL bad_char_pulse: ERROR=%b required 0", error1);
        end
        // In HUNT these 32 digits must all be discarded
        send_str("34");
        send_str("567890123456789012345678901234");
        idle(3);
        tests_run++;
        if ((wr1 - s) !== 0 || (ep1 - e) !== 1) begin
            tests_failed++;
            $display("FAIL bad_char_hunt: writes=%0d errors=%0d required 0 1", wr1 - s, ep1 - e);
        end
    endtask

    task automatic test_short_line();
        int s = wr1;
        int e = ep1;
        send_char(8'h0A);
        send_str("12345");
        send_char(8'h0D);
        send_char(8'h0A);
        send_char(8'h0A);
        send_str("FFFFFFFFFFFFFFFF");
        send_char(8'h0D);
        send_str("FFFFFFFFFFFFFFFF");
        tests_run++;
        if (write1 !== 1'b1 || data1 !== W_ONES) begin
            tests_failed++;
            $display("FAIL short_word: wr=%b data=%h required 1 %h", write1, data1, W_ONES);
        end
        idle(1);
        tests_run++;
        if ((ep1 - e) !== 1 || (wr1 - s) !== 1 || errc1 !== 8'd2) begin
            tests_failed++;
            $display("FAIL short_counts: errors=%0d writes=%0d ERR_COUNT=%0d required 1 1 2",
                     ep1 - e, wr1 - s, errc1);
        end
    endtask

    task automatic test_err_saturate();
        int e = ep1;
        for (int i = 0; i < 300; i++) begin
            send_char(8'h0A);
            send_char(8'h58);
        end
        idle(2);
        tests_run++;
        if (errc1 !== 8'd255 || errc0 !== 8'd255) begin
            tests_failed++;
            $display("FAIL err_saturate: ERR_COUNT=%0d/%0d required 255/255", errc1, errc0);
        end
        tests_run++;
        if ((ep1 - e) !== 300) begin
            tests_failed++; $display("FAIL err_pulses: got %0d required 300", ep1 - e);
        end
    endtask

    task automatic test_lowercase();
        int s1 = wr1;
        int s0 = wr0;
        int e1 = ep1;
        int e0 = ep0;
        send_char(8'h0A);
        send_str("abcdef0123456789abcdef0123456789");
        tests_run++;
        if (write1 !== 1'b1 || data1 !== W_LOWER) begin
            tests_failed++;
            $display("FAIL lower_en1: wr=%b data=%h required 1 %h", write1, data1, W_LOWER);
        end
        idle(2);
        tests_run++;
        if ((wr1 - s1) !== 1 || (ep1 - e1) !== 0) begin
            tests_failed++;
            $display("FAIL lower_en1_counts: writes=%0d errors=%0d required 1 0",
                     wr1 - s1, ep1 - e1);
        end
        tests_run++;
        if ((wr0 - s0) !== 0 || (ep0 - e0) !== 1) begin
            tests_failed++;
            $display("FAIL lower_en0: writes=%0d errors=%0d required 0 1", wr0 - s0, ep0 - e0);
        end
    endtask

    task automatic test_reset_mid();
        int s = wr1;
        fifo_full = 1'b1;
        send_char(8'h0A);
        send_str("0123456789ABCDEF0123456789ABCDEF");
        tests_run++;
        if (ready1 !== 1'b0) begin
            tests_failed++; $display("FAIL mid_push_state: ASCII_READY=%b required 0", ready1);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({write1, ready1, error1, errc1, data1} !== {1'b0, 1'b1, 1'b0, 8'd0, 128'd0}) begin
            tests_failed++;
            $display("FAIL mid_push_reset: wr/rdy/err/cnt=%b/%b/%b/%0d data=%h required 0/1/0/0 0",
                     write1, ready1, error1, errc1, data1);
        end
        idle(2);
        fifo_full = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(3);
        tests_run++;
        if ((wr1 - s) !== 0) begin
            tests_failed++; $display("FAIL mid_push_nowrite: writes=%0d required 0", wr1 - s);
        end
        send_char(8'h0A);
        send_str("01234567890123456789");
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        send_str("012345678901");
        idle(3);
        tests_run++;
        if ((wr1 - s) !== 0) begin
            tests_failed++; $display("FAIL mid_collect_nowrite: writes=%0d required 0", wr1 - s);
        end
        send_char(8'h0A);
        send_str("FEDCBA9876543210FEDCBA9876543210");
        idle(1);
        tests_run++;
        if ((wr1 - s) !== 1 || wdata1 !== W_DESC) begin
            tests_failed++;
            $display("FAIL post_reset_word: writes=%0d data=%h required 1 %h",
                     wr1 - s, wdata1, W_DESC);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_full();
        test_bad_char();
        test_short_line();
        test_err_saturate();
        test_lowercase();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
